// File: rtl/ps2_transmitter.sv
`timescale 1ns/1ps
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data + odd parity + stop, then ACK check.
// Latency: ~INHIBIT_CYCLES+RTS_CYCLES before SEND, then paced by device clocks; all outputs registered.
// Backpressure: tx_ready is high only in IDLE; tx_valid outside IDLE is dropped, nothing is queued.
module ps2_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int unsigned CW = $clog2(INHIBIT_CYCLES + RTS_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          c_oe_q, c_oe_d;
  logic          d_oe_q, d_oe_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [7:0]    c_sh_q, d_sh_q;
  logic          c_f_q, d_f_q;
  logic          c_prev_q;
  logic          fall_q;
  logic          timeout;

  // Pin filters: a level only changes after 8 identical samples; fall is registered once more.
  always_ff @(posedge clk) begin
    if (!clr) begin
      c_sh_q   <= 8'hFF;
      d_sh_q   <= 8'hFF;
      c_f_q    <= 1'b1;
      d_f_q    <= 1'b1;
      c_prev_q <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      c_sh_q <= {c_sh_q[6:0], ps2c};
      d_sh_q <= {d_sh_q[6:0], ps2d};
      if (&c_sh_q)       c_f_q <= 1'b1;
      else if (~|c_sh_q) c_f_q <= 1'b0;
      if (&d_sh_q)       d_f_q <= 1'b1;
      else if (~|d_sh_q) d_f_q <= 1'b0;
      c_prev_q <= c_f_q;
      fall_q   <= c_prev_q & ~c_f_q;
    end
  end

  assign timeout = (to_q == TW'(TIMEOUT_CYCLES - 1));

  // Next-state and registered-output logic; timeout outranks a coincident fall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    c_oe_d  = c_oe_q;
    d_oe_d  = d_oe_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          bit_d   = 4'd0;
          cnt_d   = '0;
          c_oe_d  = 1'b1;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          d_oe_d  = 1'b1;
          state_d = S_RTS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RTS: begin
        to_d = '0;
        if (cnt_q == CW'(RTS_CYCLES - 1)) begin
          cnt_d   = '0;
          c_oe_d  = 1'b0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEND: begin
        to_d = to_q + TW'(1);
        if (!timeout && fall_q) begin
          d_oe_d = ~frame_q[bit_q];
          bit_d  = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        to_d   = to_q + TW'(1);
        d_oe_d = 1'b0;
        if (!timeout && fall_q) begin
          if (!d_f_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        to_d = to_q + TW'(1);
        if (!timeout && c_f_q && d_f_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_IDLE) && timeout) begin
      err_d   = 1'b1;
      c_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      state_d = S_IDLE;
    end
    ready_d = (state_d == S_IDLE) && !done_d && !err_d;
    busy_d  = (state_d != S_IDLE);
  end

  // State, counters and output registers; reset wins over everything, mid-frame included.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      bit_q   <= 4'd0;
      frame_q <= '0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_err   = err_q;
  assign ps2c_oe  = c_oe_q;
  assign ps2d_oe  = d_oe_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
`timescale 1ns/1ps
// Bench for ps2_transmitter: open-drain pins plus a keyboard model that clocks frames in.
// Expected outcomes are queued per send; a monitor pops one on every tx_done/tx_err pulse.
// Timing of inhibit/RTS/timeout is measured in cycles against fixed constants.
module tb_ps2_transmitter;
  localparam int INH = 5000;
  localparam int RTS = 64;
  localparam int TO  = 3000;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       clr;
  logic       ps2c, ps2d;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe;
  logic       dev_c_low, dev_d_low, glitch;

  typedef struct {
    logic [9:0] bits;
    logic       done;
    logic       chk_bits;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] dev_bits;
  int         dev_nbits;

  always #5 clk = ~clk;

  assign ps2c = ~(ps2c_oe | dev_c_low | glitch);
  assign ps2d = ~(ps2d_oe | dev_d_low);

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .clr(clr), .ps2c(ps2c), .ps2d(ps2d),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Measures inhibit and RTS lengths; returns at the first negedge with ps2c released.
  task automatic phase_check();
    int n;
    chk("c_oe after accept", ps2c_oe, 1);
    chk("d_oe after accept", ps2d_oe, 0);
    chk("busy after accept", tx_busy, 1);
    chk("ready after accept", tx_ready, 0);
    n = 0;
    while (!ps2d_oe && n < INH + 100) begin @(negedge clk); n++; end
    chk("inhibit length", n, INH);
    chk("c_oe held in rts", ps2c_oe, 1);
    n = 0;
    while (ps2c_oe && n < RTS + 100) begin @(negedge clk); n++; end
    chk("rts length", n, RTS);
    chk("start bit driven", ps2d_oe, 1);
  endtask

  // Keyboard model: clocks in 10 bits sampled on rising clock, then an 11th clock with optional ACK.
  task automatic dev_run(input bit ack, input bit disturb);
    dev_nbits = 0;
    dev_bits  = '0;
    tick(20);
    chk("start bit on pin", ps2d, 0);
    for (int i = 0; i < 10; i++) begin
      dev_c_low = 1'b1;
      tick(H);
      dev_c_low   = 1'b0;
      dev_bits[i] = ps2d;
      dev_nbits++;
      if (disturb && i == 2) begin
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(H - 1);
      end else if (disturb && i == 5) begin
        tick(10);
        glitch = 1'b1;
        tick(5);
        glitch = 1'b0;
        tick(H - 15);
      end else begin
        tick(H);
      end
    end
    if (ack) dev_d_low = 1'b1;
    tick(20);
    dev_c_low = 1'b1;
    tick(H);
    dev_c_low = 1'b0;
    tick(5);
    dev_d_low = 1'b0;
    tick(H);
  endtask

  // Scoreboard monitor: every completion pulse is checked against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_done || tx_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected pulse", {30'd0, tx_done, tx_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("outcome done", tx_done, e.done);
          chk("outcome err", tx_err, !e.done);
          chk("lines released at pulse", {ps2c_oe, ps2d_oe}, 0);
          if (e.chk_bits) begin
            chk("device bit count", dev_nbits, 10);
            chk("device frame bits", dev_bits, e.bits);
          end
          @(negedge clk);
          chk("pulse single cycle", tx_done | tx_err, 0);
          chk("ready after pulse", tx_ready, 1);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    clr = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_c_low = 1'b0; dev_d_low = 1'b0; glitch = 1'b0;
    tick(4);
    chk("reset ready", tx_ready, 1);
    chk("reset busy", tx_busy, 0);
    chk("reset pulses", {tx_done, tx_err}, 0);
    chk("reset oe", {ps2c_oe, ps2d_oe}, 0);
    clr = 1'b1;
    tick(20);

    // 0xED: bits 1,0,1,1,0,1,1,1 parity 1 stop 1, ACKed
    exp_q.push_back('{10'h3ED, 1'b1, 1'b1});
    request(8'hED); phase_check(); dev_run(1'b1, 1'b0); tick(30);
    chk("idle after ED", tx_ready, 1);

    // 0xF4: bits 0,0,1,0,1,1,1,1 parity 0, ACKed
    exp_q.push_back('{10'h2F4, 1'b1, 1'b1});
    request(8'hF4); phase_check(); dev_run(1'b1, 1'b0); tick(30);
    chk("idle after F4", tx_ready, 1);

    // 0x00: parity 1, device withholds ACK
    exp_q.push_back('{10'h300, 1'b0, 1'b1});
    request(8'h00); phase_check(); dev_run(1'b0, 1'b0); tick(30);
    chk("idle after nack", tx_ready, 1);
    chk("lines after nack", {ps2c_oe, ps2d_oe}, 0);

    // 0xFF: device never clocks, timeout counted from SEND entry
    exp_q.push_back('{10'h000, 1'b0, 1'b0});
    request(8'hFF); phase_check();
    n = 0;
    while (!tx_err && n < TO + 100) begin @(negedge clk); n++; end
    chk("timeout latency", n, TO);
    tick(30);

    // 0xED aborted by reset after fall 5
    request(8'hED); phase_check();
    dev_nbits = 0; dev_bits = '0;
    tick(20);
    for (int i = 0; i < 4; i++) begin
      dev_c_low = 1'b1; tick(H);
      dev_c_low = 1'b0; dev_bits[i] = ps2d; dev_nbits++; tick(H);
    end
    chk("partial bits", dev_bits[3:0], 4'b1101);
    dev_c_low = 1'b1; tick(H);
    chk("bit4 driven before reset", ps2d_oe, 1);
    clr = 1'b0; tick(1);
    chk("abort oe", {ps2c_oe, ps2d_oe}, 0);
    chk("abort busy", tx_busy, 0);
    chk("abort pulses", {tx_done, tx_err}, 0);
    chk("abort ready", tx_ready, 1);
    clr = 1'b1; dev_c_low = 1'b0;
    tick(50);

    // fresh 0xED after reset
    exp_q.push_back('{10'h3ED, 1'b1, 1'b1});
    request(8'hED); phase_check(); dev_run(1'b1, 1'b0); tick(30);

    // 0xED with 0xAA requested mid-frame and a 5-cycle clock glitch
    exp_q.push_back('{10'h3ED, 1'b1, 1'b1});
    request(8'hED); phase_check(); dev_run(1'b1, 1'b1); tick(10);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ps2c_oe || tx_busy) seen = 1'b1;
    end
    chk("dropped byte not sent", seen, 0);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
